if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Sequencing controller for the instruction-fetch stage of the ARM pipeline. It drives a multi-cycle instruction memory through a req/ready handshake and generates the PC register freeze. It holds the fetched word in a one-entry buffer in front of the IF/ID register, and cancels in-flight or buffered fetches on a taken branch. It sits between the PC register and the IF/ID pipeline register and takes `hazard` from the hazard unit and `branch_taken` from EXE.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `NOP_INSTR`, default 32'h0000_0000: value driven on `if_instr` whenever the buffer is empty.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hazard` in 1: ID stage cannot accept an instruction this cycle.
- `branch_taken` in 1: one-cycle pulse; the PC register loads the branch address this cycle.
- `mem_ready` in 1: instruction memory completes the current request; `mem_rdata` is valid this cycle.
- `mem_rdata` in 32: instruction word from memory.
- `mem_req` out 1: fetch request; memory samples PC on the first cycle of each request.
- `pc_freeze` out 1: to the PC register `freeze`; 0 means PC updates this cycle.
- `if_flush` out 1: flush pulse to the IF/ID register.
- `if_valid` out 1: `if_instr` holds a valid instruction for ID.
- `if_instr` out 32: buffered instruction.
- `fetch_cnt` out CNT_W: instructions delivered to ID.
- `stall_cnt` out CNT_W: cycles a valid instruction was held by `hazard`.

## Operation
- States are IDLE, FETCH, DELIVER and DRAIN. The state register, buffer and counters update only on the rising edge of `clk`.
- `mem_req` = (state == FETCH || state == DRAIN). It is decoded from the state register, so it has no combinational path from inputs.
- `if_valid` = (state == DELIVER). `if_instr` is the buffer register, which equals NOP_INSTR whenever it is not valid.
- `if_flush` = `branch_taken`, combinational, in every state including IDLE.
- IDLE: `pc_freeze`=1. Always goes to FETCH next cycle.
- FETCH, memory handshake:
  - `mem_ready`=0 with no branch: stay in FETCH, `pc_freeze`=1.
  - `mem_ready`=1 with no branch: capture `mem_rdata` into the buffer, set `pc_freeze`=0 (PC+4 is loaded), go to DELIVER.
- FETCH, taken branch:
  - `branch_taken`=1 and `mem_ready`=1: discard the data, set `pc_freeze`=0 (target is loaded), stay in FETCH. The next cycle starts a new request.
  - `branch_taken`=1 and `mem_ready`=0: set `pc_freeze`=0 (target is loaded) and go to DRAIN. The outstanding request must still complete.
- DRAIN:
  - `mem_req` is held high until `mem_ready`; the returned data is discarded.
  - On `mem_ready`, go to FETCH with `pc_freeze`=1, so the new request samples the branch target.
  - Another `branch_taken` in DRAIN sets `pc_freeze`=0, loading the new target, and the block stays in DRAIN. If `mem_ready` also arrives that cycle, go to FETCH.
- DELIVER:
  - `hazard`=1: hold the buffer, `pc_freeze`=1, `stall_cnt`+1.
  - `hazard`=0: the instruction is consumed by IF/ID this cycle. `fetch_cnt`+1, buffer cleared to NOP_INSTR, go to FETCH.
  - `branch_taken`=1 has priority over `hazard`. The buffer is flushed to NOP_INSTR, no counter increments, `pc_freeze`=0, go to FETCH.
- Counters saturate at all-ones and do not wrap.
- `hazard` has no effect in IDLE, FETCH or DRAIN.

## Timing
- Reset values: state IDLE, `mem_req`=0, `pc_freeze`=1, `if_valid`=0, `if_instr`=NOP_INSTR, `fetch_cnt`=0, `stall_cnt`=0. `if_flush` follows `branch_taken` even while `rst` is high.
- Reset mid-request: any outstanding request is abandoned. The memory must tolerate `mem_req` dropping without `mem_ready`.
- First `mem_req` is the second cycle after `rst` deasserts (IDLE, then FETCH).
- Fetch latency: with N wait cycles, `mem_ready` arrives N cycles after `mem_req` rises. `if_valid` rises on the cycle after `mem_ready`.
- Throughput: 1 instruction per (N+2) cycles with no stalls; N=0 gives 1 per 2 cycles.
- `pc_freeze` is low for exactly one cycle per delivered instruction and exactly one cycle per `branch_taken`.

## Test plan
- Reset, then zero-wait memory returning 32'hE3A00014, `hazard`=0. Required: `mem_req` high from cycle 2; `if_valid`/`if_instr`=E3A00014 on cycle 3; `pc_freeze`=0 on cycle 2 only; `fetch_cnt`=1 after cycle 3.
- Two-wait memory, `hazard`=1 held 3 cycles in DELIVER. Required: `if_instr` stable for 4 cycles; `stall_cnt`=3; `fetch_cnt`=1; `pc_freeze`=1 throughout the hold.
- `branch_taken` in FETCH with `mem_ready`=0, ready arriving 2 cycles later with 32'hDEADBEEF. Required: state DRAIN; data discarded, `if_valid` stays 0; `if_flush`=1 in the branch cycle only; next `mem_req` samples the target.
- `branch_taken` together with `hazard`=1 in DELIVER. Required: next cycle `if_valid`=0 and `if_instr`=NOP_INSTR; `stall_cnt` and `fetch_cnt` unchanged; `pc_freeze`=0 in the branch cycle.
- `branch_taken` on the same cycle as `mem_ready` in FETCH. Required: no DELIVER; FETCH again next cycle with exactly one `pc_freeze`=0 cycle.
- CNT_W=4, 20 consecutive stalled cycles, then `rst` asserted mid-request. Required: `stall_cnt` saturates at 15; after reset all outputs take their reset values and `mem_req`=0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencing controller.
// Drives a multi-cycle instruction memory over a req/ready handshake and
// generates the PC register freeze. It buffers one fetched word in front of
// the IF/ID register and cancels in-flight or buffered fetches on a taken
// branch. It also keeps saturating delivered-instruction and hazard-stall
// counters.
module if_fetch_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             mem_req,
    output logic             pc_freeze,
    output logic             if_flush,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [31:0]      buf_q, buf_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Outputs decoded from registered state; only the flush is combinational.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign if_valid  = (state_q == S_DELIVER);
    assign if_instr  = buf_q;
    assign if_flush  = branch_taken;
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state, buffer, counter and PC-freeze decode.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        pc_freeze   = 1'b1;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (branch_taken) begin
                    // Target is loaded now; a request still awaiting its
                    // ready must complete in DRAIN before re-issuing.
                    pc_freeze = 1'b0;
                    state_d   = mem_ready ? S_FETCH : S_DRAIN;
                end else if (mem_ready) begin
                    buf_d     = mem_rdata;
                    pc_freeze = 1'b0;
                    state_d   = S_DELIVER;
                end
            end

            S_DRAIN: begin
                if (branch_taken) begin
                    pc_freeze = 1'b0;
                end
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_DELIVER: begin
                if (branch_taken) begin
                    buf_d     = NOP_INSTR;
                    pc_freeze = 1'b0;
                    state_d   = S_FETCH;
                end else if (hazard) begin
                    if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + CNT_ONE;
                    end
                end else begin
                    if (fetch_cnt_q != '1) begin
                        fetch_cnt_d = fetch_cnt_q + CNT_ONE;
                    end
                    buf_d   = NOP_INSTR;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
                buf_d   = NOP_INSTR;
            end
        endcase
    end

    // State, buffer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_q       <= NOP_INSTR;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed per-cycle vectors. The stimulus
// process queues the outputs expected in each cycle; a monitor pops and
// compares them mid-cycle.
module tb_if_fetch_ctrl;

    localparam int unsigned CW  = 4;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hazard = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          mem_req;
    logic          pc_freeze;
    logic          if_flush;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [CW-1:0] fetch_cnt;
    logic [CW-1:0] stall_cnt;

    if_fetch_ctrl #(
        .CNT_W    (CW),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hazard      (hazard),
        .branch_taken(branch_taken),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .pc_freeze   (pc_freeze),
        .if_flush    (if_flush),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk;
        logic [43:0] vec;  // {mem_req, pc_freeze, if_flush, if_valid, instr, fcnt, scnt}
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: compare the expected outputs for the current cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [43:0] got;
            e   = exp_q.pop_front();
            got = {mem_req, pc_freeze, if_flush, if_valid, if_instr, fetch_cnt, stall_cnt};
            if (e.chk) begin
                total++;
                if (got !== e.vec) begin
                    bad++;
                    $display("FAIL %s: got req/frz/fl/vld=%b%b%b%b instr=%h f=%0d s=%0d, want req/frz/fl/vld=%b%b%b%b instr=%h f=%0d s=%0d",
                             e.name, got[43], got[42], got[41], got[40], got[39:8], got[7:4], got[3:0],
                             e.vec[43], e.vec[42], e.vec[41], e.vec[40], e.vec[39:8], e.vec[7:4], e.vec[3:0]);
                end
            end
        end
    end

    // One cycle: drive inputs just after the edge, queue that cycle's outputs.
    task automatic step(input string name, input bit chk,
                        input logic r, input logic hz, input logic br,
                        input logic rdy, input logic [31:0] rdata,
                        input logic e_req, input logic e_frz, input logic e_vld,
                        input logic [31:0] e_instr,
                        input logic [CW-1:0] e_f, input logic [CW-1:0] e_s);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        hazard       = hz;
        branch_taken = br;
        mem_ready    = rdy;
        mem_rdata    = rdata;
        e.name = name;
        e.chk  = chk;
        e.vec  = {e_req, e_frz, br, e_vld, e_instr, e_f, e_s};
        exp_q.push_back(e);
    endtask

    initial begin
        logic [CW-1:0] sx;

        // Reset; flush must follow branch_taken even in reset.
        step("rst0",        0, 1,0,0,0,'0,            0,1,0,NOP,4'd0,4'd0);
        step("rst_flush",   1, 1,0,1,0,'0,            0,1,0,NOP,4'd0,4'd0);
        step("rst_state",   1, 1,0,0,0,'0,            0,1,0,NOP,4'd0,4'd0);

        // Zero-wait fetch of E3A00014.
        step("t1_idle",     1, 0,0,0,0,'0,            0,1,0,NOP,4'd0,4'd0);
        step("t1_fetch",    1, 0,0,0,1,32'hE3A00014,  1,0,0,NOP,4'd0,4'd0);
        step("t1_deliver",  1, 0,0,0,0,'0,            0,1,1,32'hE3A00014,4'd0,4'd0);
        step("t1_after",    1, 0,0,0,0,'0,            1,1,0,NOP,4'd1,4'd0);

        // Two-wait fetch, hazard held 3 cycles.
        step("t2_wait2",    1, 0,0,0,0,'0,            1,1,0,NOP,4'd1,4'd0);
        step("t2_ready",    1, 0,0,0,1,32'h11112222,  1,0,0,NOP,4'd1,4'd0);
        step("t2_hold1",    1, 0,1,0,0,'0,            0,1,1,32'h11112222,4'd1,4'd0);
        step("t2_hold2",    1, 0,1,0,0,'0,            0,1,1,32'h11112222,4'd1,4'd1);
        step("t2_hold3",    1, 0,1,0,0,'0,            0,1,1,32'h11112222,4'd1,4'd2);
        step("t2_consume",  1, 0,0,0,0,'0,            0,1,1,32'h11112222,4'd1,4'd3);
        step("t2_after",    1, 0,0,0,0,'0,            1,1,0,NOP,4'd2,4'd3);

        // Branch in FETCH without ready -> DRAIN, DEADBEEF discarded.
        step("t3_branch",   1, 0,0,1,0,'0,            1,0,0,NOP,4'd2,4'd3);
        step("t3_drain_hz", 1, 0,1,0,0,'0,            1,1,0,NOP,4'd2,4'd3);
        step("t3_drain_rdy",1, 0,0,0,1,32'hDEADBEEF,  1,1,0,NOP,4'd2,4'd3);
        step("t3_refetch",  1, 0,0,0,0,'0,            1,1,0,NOP,4'd2,4'd3);

        // Branch together with hazard in DELIVER.
        step("t4_fetch",    1, 0,0,0,1,32'h33334444,  1,0,0,NOP,4'd2,4'd3);
        step("t4_hold",     1, 0,1,0,0,'0,            0,1,1,32'h33334444,4'd2,4'd3);
        step("t4_branch",   1, 0,1,1,0,'0,            0,0,1,32'h33334444,4'd2,4'd4);
        step("t4_flushed",  1, 0,0,0,0,'0,            1,1,0,NOP,4'd2,4'd4);

        // Branch on the same cycle as ready in FETCH.
        step("t5_br_rdy",   1, 0,0,1,1,32'h55556666,  1,0,0,NOP,4'd2,4'd4);
        step("t5_refetch",  1, 0,0,0,0,'0,            1,1,0,NOP,4'd2,4'd4);
        step("t5_fetch",    1, 0,0,0,1,32'h77778888,  1,0,0,NOP,4'd2,4'd4);
        step("t5_deliver",  1, 0,0,0,0,'0,            0,1,1,32'h77778888,4'd2,4'd4);

        // Second branch while draining, with ready on the same cycle.
        step("t5b_branch",  1, 0,0,1,0,'0,            1,0,0,NOP,4'd3,4'd4);
        step("t5b_drainbr", 1, 0,0,1,1,32'hDEADBEEF,  1,0,0,NOP,4'd3,4'd4);
        step("t5b_refetch", 1, 0,0,0,0,'0,            1,1,0,NOP,4'd3,4'd4);

        // Stall counter saturation, then reset mid-request.
        step("t6_fetch",    1, 0,0,0,1,32'h9999AAAA,  1,0,0,NOP,4'd3,4'd4);
        for (int k = 0; k < 20; k++) begin
            sx = (4 + k > 15) ? 4'd15 : CW'(4 + k);
            step("t6_stall",  1, 0,1,0,0,'0,          0,1,1,32'h9999AAAA,4'd3,sx);
        end
        step("t6_sat",      1, 0,0,0,0,'0,            0,1,1,32'h9999AAAA,4'd3,4'd15);
        step("t6_req",      1, 0,0,0,0,'0,            1,1,0,NOP,4'd4,4'd15);
        step("t6_rst_req",  1, 1,0,0,0,'0,            1,1,0,NOP,4'd4,4'd15);
        step("t6_post_rst", 1, 0,0,0,0,'0,            0,1,0,NOP,4'd0,4'd0);
        step("t6_refetch",  1, 0,0,0,0,'0,            1,1,0,NOP,4'd0,4'd0);

        // Let the monitor consume the last entry, bounded.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
